// File: rtl/debug_pkg.sv
// Shared constants for the register-dump UART: ASCII codes, FSM states,
// line/header geometry and the per-byte text formatting helpers.
// Optional header text is compiled in with REG_DUMP_HEADER_EN.
package debug_pkg;

    localparam logic [7:0] CH_X  = 8'h78;  // 'x'
    localparam logic [7:0] CH_EQ = 8'h3D;  // '='
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;  // '0'
    localparam logic [7:0] CH_A  = 8'h41;  // 'A'

    localparam int LINE_LEN = 14;          // "xNN=HHHHHHHH\r\n"
    localparam int HDR_LEN  = 6;           // "REGS\r\n"

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_CAPT,
        ST_SEND,
        ST_NEXT,
        ST_FIN
    } state_e;

    // One uppercase hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? CH_0 + {4'h0, n} : CH_A + {4'h0, n} - 8'd10;
    endfunction

    // Byte k (0..13) of the text line for register idx holding val.
    function automatic logic [7:0] line_byte(input logic [3:0] k, input logic [4:0] idx,
                                             input logic [31:0] val);
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] nib;
        logic [7:0] b;
        tens  = (idx >= 5'd30) ? 4'd3 : (idx >= 5'd20) ? 4'd2 : (idx >= 5'd10) ? 4'd1 : 4'd0;
        units = 4'(idx - 5'(tens) * 5'd10);
        // bytes 4..11 carry nibbles 7..0, most significant first
        nib   = 4'(val >> {(4'd11 - k), 2'b00});
        case (k)
            4'd0:    b = CH_X;
            4'd1:    b = CH_0 + {4'h0, tens};
            4'd2:    b = CH_0 + {4'h0, units};
            4'd3:    b = CH_EQ;
            4'd12:   b = CH_CR;
            4'd13:   b = CH_LF;
            default: b = hex_ascii(nib);
        endcase
        return b;
    endfunction

    // Byte k (0..5) of the "REGS\r\n" banner.
    function automatic logic [7:0] hdr_byte(input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = 8'h52;
            3'd1:    b = 8'h45;
            3'd2:    b = 8'h47;
            3'd3:    b = 8'h53;
            3'd4:    b = CH_CR;
            default: b = CH_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, idle high. tx_ready is also high in the
// last cycle of the stop bit so a waiting byte follows with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          active_q;
    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;     // 0 start, 1..8 data, 9 stop
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          bit_end;
    logic          frame_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = bit_end && (bit_q == 4'd9);
    assign tx_ready  = !active_q || frame_end;
    assign tx        = tx_q;

    // Baud/bit counters and line driver; accepting a byte starts its start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
        end else if (tx_ready && tx_valid) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= tx_data;
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    bit_q    <= '0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[7:1]};
                    end
                end
            end else begin
                baud_q <= baud_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_uart.sv
// Streams the register file as "xNN=HHHHHHHH\r\n" lines over a UART.
// Define REG_DUMP_HEADER_EN to prefix the dump with "REGS\r\n".
module reg_dump_uart
    import debug_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dump_req,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
    localparam logic [3:0] LAST_BYTE = 4'(LINE_LEN - 1);

    state_e      state_q;
    logic [4:0]  idx_q;
    logic [3:0]  byte_q;      // byte currently on the wire
    logic [31:0] shadow_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  raddr_q;
`ifdef REG_DUMP_HEADER_EN
    localparam logic [3:0] HDR_LAST = 4'(HDR_LEN - 1);
    // 2: lead-in cycle (keeps start bit at the same latency), 1: first byte pending, 0: streaming
    logic [1:0]  hph_q;
`endif

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    assign busy     = busy_q;
    assign done     = done_q;
    assign rf_raddr = raddr_q;

    // Byte offered to the transmitter; SEND always offers the byte after the one in flight.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = CH_X;
        case (state_q)
            ST_CAPT: begin
                tx_valid = 1'b1;
                tx_data  = CH_X;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = line_byte(byte_q + 4'd1, idx_q, shadow_q);
            end
`ifdef REG_DUMP_HEADER_EN
            ST_HDR: begin
                tx_valid = (hph_q == 2'd1) || (hph_q == 2'd0 && byte_q != HDR_LAST);
                tx_data  = hdr_byte((hph_q == 2'd1) ? 3'd0 : 3'(byte_q + 4'd1));
            end
`endif
            default: ;
        endcase
    end

    // Dump sequencer: per register ADDR -> CAPT -> SEND -> NEXT, then FIN pulses done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            byte_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            raddr_q  <= '0;
`ifdef REG_DUMP_HEADER_EN
            hph_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dump_req) begin
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        raddr_q <= '0;
                        byte_q  <= '0;
`ifdef REG_DUMP_HEADER_EN
                        hph_q   <= 2'd2;
                        state_q <= ST_HDR;
`else
                        state_q <= ST_ADDR;
`endif
                    end
                end
`ifdef REG_DUMP_HEADER_EN
                ST_HDR: begin
                    if (hph_q == 2'd2) begin
                        hph_q <= 2'd1;
                    end else if (tx_ready) begin
                        if (hph_q == 2'd1) begin
                            hph_q <= 2'd0;
                        end else if (byte_q == HDR_LAST) begin
                            byte_q  <= '0;
                            state_q <= ST_ADDR;
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                end
`endif
                ST_ADDR: state_q <= ST_CAPT;
                ST_CAPT: begin
                    // read data for raddr_q is valid now; 'x' is handed off on this edge
                    shadow_q <= rf_rdata;
                    byte_q   <= '0;
                    state_q  <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        byte_q <= byte_q + 4'd1;
                        if (byte_q == LAST_BYTE - 4'd1) state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // wait out the LF stop bit before moving on
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            raddr_q <= idx_q + 5'd1;
                            state_q <= ST_ADDR;
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .resetn   (resetn),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (uart_tx)
    );

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: UART decoder + scoreboard against text built from the rf model.
`timescale 1ns/1ps
module tb_reg_dump_uart;

    localparam int CPB  = 8;
    localparam int NREG = 32;
`ifdef REG_DUMP_HEADER_EN
    localparam int HDR_N = 6;
`else
    localparam int HDR_N = 0;
`endif
    localparam int DUMP_BYTES = HDR_N + NREG * 14;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        dump_req = 1'b0;
    logic        busy, done, uart_tx;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;

    logic [31:0] rf [NREG];
    logic [7:0]  exp_q [$];
    int ncmp = 0;
    int nerr = 0;
    int rx_cnt = 0;
    int done_cnt = 0;

    reg_dump_uart #(.CLK_FREQ(8), .BAUD(1), .NUM_REGS(NREG)) dut (
        .clk(clk), .resetn(resetn), .dump_req(dump_req), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // register file model with one-cycle synchronous read
    always @(posedge clk) rf_rdata <= rf[rf_raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // expected text of a full dump from current rf contents
    task automatic push_dump();
        logic [7:0] h [6];
        h = '{8'h52, 8'h45, 8'h47, 8'h53, 8'h0D, 8'h0A};
        for (int i = 0; i < HDR_N; i++) exp_q.push_back(h[i]);
        for (int i = 0; i < NREG; i++) begin
            exp_q.push_back(8'h78);
            exp_q.push_back(8'h30 + 8'(i / 10));
            exp_q.push_back(8'h30 + 8'(i % 10));
            exp_q.push_back(8'h3D);
            for (int n = 7; n >= 0; n--) exp_q.push_back(hexc(4'(rf[i] >> (4 * n))));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // ideal line level k cycles after the first start bit, for two back-to-back bytes
    function automatic logic frame_bit(input logic [7:0] b0, input logic [7:0] b1, input int k);
        logic [7:0] b;
        int p;
        b = (k < 10 * CPB) ? b0 : b1;
        p = (k % (10 * CPB)) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // UART decoder + scoreboard: sample mid-bit on falling clock edges
    initial begin : rx_mon
        bit         act;
        int         cnt;
        int         b;
        logic [7:0] sh;
        logic       st_ok;
        act = 0; cnt = 0; sh = '0; st_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                act = 0;
                rx_cnt = 0;
            end else if (!act) begin
                if (uart_tx == 1'b0) begin
                    act = 1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB / 2) begin
                    st_ok = (uart_tx == 1'b0);
                end else if (cnt > CPB / 2 && (cnt - CPB / 2) % CPB == 0) begin
                    b = (cnt - CPB / 2) / CPB;
                    if (b <= 8) begin
                        sh[b-1] = uart_tx;
                    end else begin
                        act = 0;
                        rx_cnt++;
                        check("frame_start_stop", {st_ok, uart_tx}, 2'b11);
                        if (exp_q.size() == 0) begin
                            ncmp++;
                            nerr++;
                            $display("FAIL extra_byte: got %02h expected none", sh);
                        end else begin
                            check("byte", sh, exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // done monitor
    initial forever begin
        @(negedge clk);
        if (resetn && done === 1'b1) begin
            done_cnt++;
            check("busy_at_done", busy, 1'b0);
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("wait_rx_timeout", (rx_cnt >= n), 1'b1);
    endtask

    initial begin : stim
        logic [7:0] fb0, fb1;
        int errs;
        int t;

        // 1: reset
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        rf[5] = 32'h0000ABCD;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_raddr", rf_raddr, 5'd0);
        resetn = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check("idle_100", errs, 0);

        // 2/3/4: full dump with timing and ignored requests
        push_dump();
        fb0 = exp_q[0];
        fb1 = exp_q[1];
        @(negedge clk) dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
        check("busy_at_n", busy, 1'b1);
        check("raddr_at_n", rf_raddr, 5'd0);
        check("tx_at_n", uart_tx, 1'b1);
        @(posedge clk);
        #1 check("tx_at_n1", uart_tx, 1'b1);
        errs = 0;
        for (int k = 0; k < 20 * CPB; k++) begin
            @(posedge clk);
            #1 if (uart_tx !== frame_bit(fb0, fb1, k)) errs++;
        end
        check("first_two_frames", errs, 0);
        repeat ($urandom_range(20000, 2000)) @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk) dump_req = 1'b0;
        check("busy_mid", busy, 1'b1);
        t = 0;
        while (done !== 1'b1 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", done, 1'b1);
        dump_req = 1'b1;               // lands in the done cycle
        @(negedge clk) dump_req = 1'b0;
        errs = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("quiet_after_done", errs, 0);
        check("done_count", done_cnt, 1);
        check("byte_count", rx_cnt, DUMP_BYTES);
        check("exp_left", exp_q.size(), 0);

        // 5: reset mid-byte of line 3
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        push_dump();
        @(negedge clk) dump_req = 1'b1;
        @(negedge clk) dump_req = 1'b0;
        wait_rx(HDR_N + 3 * 14 + 5, 10000);
        t = 0;
        while (uart_tx !== 1'b0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        #2 resetn = 1'b0;
        #1;
        check("async_rst_tx", uart_tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        exp_q.delete();
        #2 resetn = 1'b1;

        // restart: must begin again at x00 with fresh random data
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        push_dump();
        @(negedge clk) dump_req = 1'b1;
        @(negedge clk) dump_req = 1'b0;
        wait_rx(HDR_N + 8 * 14, 15000);
        check("restart_exp_left", exp_q.size(), DUMP_BYTES - HDR_N - 8 * 14);
        @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        exp_q.delete();
        #2 resetn = 1'b1;
        check("done_total", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
